// File: rtl/decode_ctrl_seq.sv
// decode_ctrl_seq: registered instruction decoder and execute sequencer.
// Accepts one instruction per valid/ready handshake. It drives one cycle of
// execute strobes, or runs a load/store through the req/ack data-memory port.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN. When it is defined,
// reserved opcodes enter a sticky TRAP state that only rst leaves.
module decode_ctrl_seq #(
  parameter int DataWidth         = 8,
  parameter int SEL_WIDTH         = 3,
  parameter int PROGRAM_DataWidth = 16,
  parameter int NumOpCodeBits     = 5,
  parameter int NumStatusBits     = 6,
  parameter int OP1_BIT_POS       = 10,
  parameter int OP2_BIT_POS       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PROGRAM_DataWidth-1:0] instr,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic [NumStatusBits-1:0]     status,
  output logic [NumOpCodeBits-1:0]     opcode,
  output logic [DataWidth-1:0]         literal_adr,
  output logic [SEL_WIDTH-1:0]         rd_sel1,
  output logic [SEL_WIDTH-1:0]         rd_sel2,
  output logic [SEL_WIDTH-1:0]         wr_sel,
  output logic                         rd_en1,
  output logic                         rd_en2,
  output logic                         wr_en,
  output logic [1:0]                   reg_in_sel,
  output logic                         stat_wr_en,
  output logic                         cnt_wr_en,
  output logic                         add_offset,
  output logic                         mem_req,
  output logic                         mem_we,
  input  logic                         mem_ack,
  output logic                         illegal_op
);

  typedef logic [NumOpCodeBits-1:0] op_t;

  localparam op_t OP_NOP  = op_t'(5'b00000);
  localparam op_t OP_ADD  = op_t'(5'b00001);
  localparam op_t OP_SUB  = op_t'(5'b00010);
  localparam op_t OP_AND  = op_t'(5'b00011);
  localparam op_t OP_OR   = op_t'(5'b00100);
  localparam op_t OP_XOR  = op_t'(5'b00101);
  localparam op_t OP_NOT  = op_t'(5'b00110);
  localparam op_t OP_SHL  = op_t'(5'b00111);
  localparam op_t OP_SHR  = op_t'(5'b01000);
  localparam op_t OP_VAL  = op_t'(5'b01001);
  localparam op_t OP_CMP  = op_t'(5'b01010);
  localparam op_t OP_GOTO = op_t'(5'b10000);
  localparam op_t OP_IFZ  = op_t'(5'b10001);
  localparam op_t OP_IFNZ = op_t'(5'b10010);
  localparam op_t OP_IFEQ = op_t'(5'b10011);
  localparam op_t OP_IFST = op_t'(5'b10100);
  localparam op_t OP_IFGT = op_t'(5'b10101);
  localparam op_t OP_LD   = op_t'(5'b11000);
  localparam op_t OP_ST   = op_t'(5'b11001);

  // Status register bit positions tested by the conditional branches.
  localparam int ST_ZERO  = 2;
  localparam int ST_EQUAL = 3;
  localparam int ST_GT    = 4;
  localparam int ST_ST    = 5;

  // Register-file write source encodings.
  localparam logic [1:0] REG_IN_LIT = 2'b00;
  localparam logic [1:0] REG_IN_ALU = 2'b01;
  localparam logic [1:0] REG_IN_MEM = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    MEM  = 3'd2,
    WB   = 3'd3
`ifdef DECODE_ILLEGAL_TRAP_EN
    , TRAP = 3'd4
`endif
  } state_t;

  state_t                       state, state_nxt;
  logic [PROGRAM_DataWidth-1:0] instr_q;
  op_t                          op;
  logic [SEL_WIDTH-1:0]         op1_sel, op2_sel;

  assign op          = instr_q[PROGRAM_DataWidth-1 -: NumOpCodeBits];
  assign op1_sel     = instr_q[OP1_BIT_POS -: SEL_WIDTH];
  assign op2_sel     = instr_q[OP2_BIT_POS -: SEL_WIDTH];
  assign opcode      = op;
  assign literal_adr = instr_q[DataWidth-1:0];

  // Carry and underflow are never tested by a branch.
  logic unused_status;
  assign unused_status = ^status;

  // State register and instruction latch; the latch only moves on a handshake.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state   <= IDLE;
      instr_q <= '0;
    end else begin
      state <= state_nxt;
      if (instr_valid && instr_ready) instr_q <= instr;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  function automatic logic is_legal(input op_t o);
    return o inside {OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
                     OP_SHL, OP_SHR, OP_VAL, OP_CMP, OP_GOTO, OP_IFZ, OP_IFNZ,
                     OP_IFEQ, OP_IFST, OP_IFGT, OP_LD, OP_ST};
  endfunction

  logic illegal_q;

  // Sticky trap flag: set when an illegal opcode reaches EXEC, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst)                                 illegal_q <= 1'b0;
    else if (state == EXEC && !is_legal(op)) illegal_q <= 1'b1;
  end

  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  // Next-state logic: IDLE -> EXEC -> (MEM -> [WB]) -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (instr_valid) state_nxt = EXEC;
      EXEC: begin
        state_nxt = IDLE;
        if (op == OP_LD || op == OP_ST) state_nxt = MEM;
`ifdef DECODE_ILLEGAL_TRAP_EN
        else if (!is_legal(op))         state_nxt = TRAP;
`endif
      end
      MEM:  if (mem_ack) state_nxt = (op == OP_LD) ? WB : IDLE;
      WB:   state_nxt = IDLE;
`ifdef DECODE_ILLEGAL_TRAP_EN
      TRAP: state_nxt = TRAP;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: strobes come from the latched instruction and the current state.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case infers a latch.
    instr_ready = 1'b0;
    rd_sel1     = '0;
    rd_sel2     = '0;
    wr_sel      = '0;
    rd_en1      = 1'b0;
    rd_en2      = 1'b0;
    wr_en       = 1'b0;
    reg_in_sel  = REG_IN_LIT;
    stat_wr_en  = 1'b0;
    cnt_wr_en   = 1'b0;
    add_offset  = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    case (state)
      IDLE: instr_ready = 1'b1;
      EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            rd_sel1    = op1_sel;
            rd_sel2    = op2_sel;
            wr_sel     = op1_sel;
            rd_en1     = 1'b1;
            rd_en2     = 1'b1;
            wr_en      = 1'b1;
            reg_in_sel = REG_IN_ALU;
            stat_wr_en = 1'b1;
          end
          OP_NOT: begin
            rd_sel2    = op2_sel;
            wr_sel     = op1_sel;
            rd_en2     = 1'b1;
            wr_en      = 1'b1;
            reg_in_sel = REG_IN_ALU;
            stat_wr_en = 1'b1;
          end
          OP_SHL, OP_SHR: begin
            rd_sel1    = op1_sel;
            wr_sel     = op1_sel;
            rd_en1     = 1'b1;
            wr_en      = 1'b1;
            reg_in_sel = REG_IN_ALU;
            stat_wr_en = 1'b1;
          end
          OP_VAL: begin
            wr_sel = op1_sel;
            wr_en  = 1'b1;
          end
          OP_CMP: begin
            rd_sel1    = op1_sel;
            rd_sel2    = op2_sel;
            rd_en1     = 1'b1;
            rd_en2     = 1'b1;
            stat_wr_en = 1'b1;
          end
          OP_GOTO: cnt_wr_en = 1'b1;
          // Branch conditions use === so an X or Z status bit reads as 0.
          OP_IFZ: begin
            cnt_wr_en  = (status[ST_ZERO] === 1'b1);
            add_offset = (status[ST_ZERO] === 1'b1);
          end
          OP_IFNZ: begin
            cnt_wr_en  = (status[ST_ZERO] !== 1'b1);
            add_offset = (status[ST_ZERO] !== 1'b1);
          end
          OP_IFEQ: begin
            cnt_wr_en  = (status[ST_EQUAL] === 1'b1);
            add_offset = (status[ST_EQUAL] === 1'b1);
          end
          OP_IFST: begin
            cnt_wr_en  = (status[ST_ST] === 1'b1);
            add_offset = (status[ST_ST] === 1'b1);
          end
          OP_IFGT: begin
            cnt_wr_en  = (status[ST_GT] === 1'b1);
            add_offset = (status[ST_GT] === 1'b1);
          end
          default: ;
        endcase
      end
      MEM: begin
        mem_req = 1'b1;
        if (op == OP_ST) begin
          rd_sel1 = op1_sel;
          rd_en1  = 1'b1;
          mem_we  = 1'b1;
        end
      end
      WB: begin
        wr_sel     = op1_sel;
        wr_en      = 1'b1;
        reg_in_sel = REG_IN_MEM;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_decode_ctrl_seq.sv
// Self-checking bench for decode_ctrl_seq. Expected per-cycle outputs are
// queued by each scenario as it drives stimulus and popped when that cycle's
// outputs are sampled (1 time unit after the falling edge).
module tb_decode_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst, instr_valid, instr_ready, mem_ack;
  logic [15:0] instr;
  logic [5:0]  status;
  logic [4:0]  opcode;
  logic [7:0]  literal_adr;
  logic [2:0]  rd_sel1, rd_sel2, wr_sel;
  logic        rd_en1, rd_en2, wr_en;
  logic [1:0]  reg_in_sel;
  logic        stat_wr_en, cnt_wr_en, add_offset, mem_req, mem_we, illegal_op;

  always #5 clk = ~clk;

  decode_ctrl_seq dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .status(status), .opcode(opcode),
    .literal_adr(literal_adr), .rd_sel1(rd_sel1), .rd_sel2(rd_sel2),
    .wr_sel(wr_sel), .rd_en1(rd_en1), .rd_en2(rd_en2), .wr_en(wr_en),
    .reg_in_sel(reg_in_sel), .stat_wr_en(stat_wr_en), .cnt_wr_en(cnt_wr_en),
    .add_offset(add_offset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .illegal_op(illegal_op)
  );

  typedef struct packed {
    logic       ready;
    logic [4:0] opc;
    logic [7:0] lit;
    logic [2:0] rs1, rs2, ws;
    logic       re1, re2, we;
    logic [1:0] ris;
    logic       swe, cwe, aoff, mreq, mwe, ill;
  } obs_t;

  typedef struct packed {
    logic        rst, valid;
    logic [15:0] instr;
    logic [5:0]  status;
    logic        ack;
  } in_t;

  obs_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  // Model of the architecturally visible latched fields.
  logic [4:0] m_op  = '0;
  logic [7:0] m_lit = '0;
  logic       m_ill = 1'b0;

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] op1,
                                     input logic [7:0] lit);
    return {op, op1, lit};
  endfunction

  function automatic in_t inp(input logic v, input logic [15:0] ins,
                              input logic [5:0] st, input logic ack, input logic r);
    in_t i;
    i.rst = r; i.valid = v; i.instr = ins; i.status = st; i.ack = ack;
    return i;
  endfunction

  function automatic obs_t quiet(input logic ready);
    obs_t o;
    o = '0;
    o.ready = ready; o.opc = m_op; o.lit = m_lit; o.ill = m_ill;
    return o;
  endfunction

  function automatic obs_t strb(input logic [2:0] rs1, rs2, ws, input logic re1, re2, we,
                                input logic [1:0] ris, input logic swe, cwe, aoff, mreq, mwe);
    obs_t o;
    o = quiet(1'b0);
    o.rs1 = rs1; o.rs2 = rs2; o.ws = ws; o.re1 = re1; o.re2 = re2; o.we = we;
    o.ris = ris; o.swe = swe; o.cwe = cwe; o.aoff = aoff; o.mreq = mreq; o.mwe = mwe;
    return o;
  endfunction

  // Drive one cycle's inputs at the falling edge, then compare against the queue head.
  task automatic step(input in_t i, input string name);
    obs_t got, exp;
    @(negedge clk);
    rst = i.rst; instr_valid = i.valid; instr = i.instr; status = i.status; mem_ack = i.ack;
    #1;
    got = {instr_ready, opcode, literal_adr, rd_sel1, rd_sel2, wr_sel, rd_en1, rd_en2,
           wr_en, reg_in_sel, stat_wr_en, cnt_wr_en, add_offset, mem_req, mem_we, illegal_op};
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: no expected entry queued, got=%h", name, got);
    end else begin
      exp = sb.pop_front();
      if (got !== exp) begin
        bad++;
        $display("FAIL %s: got=%h required=%h", name, got, exp);
      end
    end
  endtask

  // Handshake cycle in IDLE; the model latches the instruction afterwards.
  task automatic issue(input logic [15:0] ins, input logic [5:0] st, input string name);
    sb.push_back(quiet(1'b1));
    step(inp(1'b1, ins, st, 1'b0, 1'b0), name);
    m_op = ins[15:11]; m_lit = ins[7:0];
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0; instr = '0; status = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    m_op = '0; m_lit = '0; m_ill = 1'b0;
    sb.push_back(quiet(1'b1));
    step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b0), "reset_idle");
    sb.push_back(quiet(1'b1));
    step(inp(1'b0, 16'h0, 6'h0, 1'b1, 1'b0), "reset_idle_ack_ignored");
  endtask

  task automatic test_add();
    issue(mk(5'b00001, 3'd3, {3'b000, 3'd5, 2'b00}), 6'h0, "add_handshake");
    sb.push_back(strb(3'd3, 3'd5, 3'd3, 1, 1, 1, 2'b01, 1, 0, 0, 0, 0));
    step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b0), "add_exec");
    sb.push_back(quiet(1'b1));
    step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b0), "add_back_idle");
  endtask

  task automatic test_val();
    issue(mk(5'b01001, 3'd2, 8'hA5), 6'h3f, "val_handshake");
    sb.push_back(strb(3'd0, 3'd0, 3'd2, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0));
    step(inp(1'b0, 16'h0, 6'h3f, 1'b0, 1'b0), "val_exec");
    sb.push_back(quiet(1'b1));
    step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b0), "val_back_idle");
  endtask

  task automatic test_ops();
    logic [15:0] t_ins[6];
    obs_t        t_exp[6];
    obs_t        e;
    t_ins[0] = mk(5'b00110, 3'd6, {3'b000, 3'd1, 2'b00});  // NOT r6,r1
    t_exp[0] = strb(3'd0, 3'd1, 3'd6, 0, 1, 1, 2'b01, 1, 0, 0, 0, 0);
    t_ins[1] = mk(5'b01000, 3'd7, 8'hFF);                  // SHR r7
    t_exp[1] = strb(3'd7, 3'd0, 3'd7, 1, 0, 1, 2'b01, 1, 0, 0, 0, 0);
    t_ins[2] = mk(5'b01010, 3'd1, {3'b000, 3'd2, 2'b00});  // CMP r1,r2
    t_exp[2] = strb(3'd1, 3'd2, 3'd0, 1, 1, 0, 2'b00, 1, 0, 0, 0, 0);
    t_ins[3] = mk(5'b10000, 3'd0, 8'h33);                  // GOTO
    t_exp[3] = strb(3'd0, 3'd0, 3'd0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0);
    t_ins[4] = mk(5'b00000, 3'd5, 8'h5C);                  // NOP
    t_exp[4] = strb(3'd0, 3'd0, 3'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    t_ins[5] = mk(5'b00111, 3'd2, 8'h00);                  // SHL r2
    t_exp[5] = strb(3'd2, 3'd0, 3'd2, 1, 0, 1, 2'b01, 1, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      issue(t_ins[k], 6'h0, $sformatf("op%0d_handshake", k));
      e = t_exp[k]; e.opc = m_op; e.lit = m_lit;
      sb.push_back(e);
      step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b0), $sformatf("op%0d_exec", k));
      sb.push_back(quiet(1'b1));
      step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b0), $sformatf("op%0d_idle", k));
    end
  endtask

  task automatic test_branch();
    logic [4:0] b_op[8];
    logic [5:0] b_hs[8], b_st[8];
    logic       b_tk[8];
    b_op[0] = 5'b10101; b_hs[0] = 6'b000000; b_st[0] = 6'b010000; b_tk[0] = 1;  // IFGT
    b_op[1] = 5'b10101; b_hs[1] = 6'b111111; b_st[1] = 6'b000000; b_tk[1] = 0;
    b_op[2] = 5'b10010; b_hs[2] = 6'b111111; b_st[2] = 6'b000x00; b_tk[2] = 1;  // IFNZ, X
    b_op[3] = 5'b10001; b_hs[3] = 6'b111111; b_st[3] = 6'b000x00; b_tk[3] = 0;  // IFZ, X
    b_op[4] = 5'b10001; b_hs[4] = 6'b000000; b_st[4] = 6'b000100; b_tk[4] = 1;
    b_op[5] = 5'b10011; b_hs[5] = 6'b000000; b_st[5] = 6'b001000; b_tk[5] = 1;  // IFEQ
    b_op[6] = 5'b10100; b_hs[6] = 6'b000000; b_st[6] = 6'b100000; b_tk[6] = 1;  // IFST
    b_op[7] = 5'b10100; b_hs[7] = 6'b111111; b_st[7] = 6'b011111; b_tk[7] = 0;
    for (int k = 0; k < 8; k++) begin
      issue(mk(b_op[k], 3'd4, 8'h12), b_hs[k], $sformatf("br%0d_handshake", k));
      sb.push_back(strb(3'd0, 3'd0, 3'd0, 0, 0, 0, 2'b00, 0, b_tk[k], b_tk[k], 0, 0));
      step(inp(1'b0, 16'h0, b_st[k], 1'b0, 1'b0), $sformatf("br%0d_exec", k));
      sb.push_back(quiet(1'b1));
      step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b0), $sformatf("br%0d_idle", k));
    end
  endtask

  task automatic test_load();
    issue(mk(5'b11000, 3'd1, 8'h40), 6'h0, "ld_handshake");
    sb.push_back(quiet(1'b0));
    step(inp(1'b0, 16'h0, 6'h0, 1'b1, 1'b0), "ld_exec_ack_ignored");
    for (int k = 0; k < 4; k++) begin
      sb.push_back(strb(3'd0, 3'd0, 3'd0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0));
      step(inp(1'b0, 16'h0, 6'h0, (k == 3), 1'b0), $sformatf("ld_mem%0d", k));
    end
    sb.push_back(strb(3'd0, 3'd0, 3'd1, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0));
    step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b0), "ld_wb");
    sb.push_back(quiet(1'b1));
    step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b0), "ld_idle");
  endtask

  task automatic test_store_fast();
    issue(mk(5'b11001, 3'd5, 8'h22), 6'h0, "st_fast_handshake");
    sb.push_back(quiet(1'b0));
    step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b0), "st_fast_exec");
    sb.push_back(strb(3'd5, 3'd0, 3'd0, 1, 0, 0, 2'b00, 0, 0, 0, 1, 1));
    step(inp(1'b0, 16'h0, 6'h0, 1'b1, 1'b0), "st_fast_mem_ack");
    sb.push_back(quiet(1'b1));
    step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b0), "st_fast_idle");
  endtask

  task automatic test_store_reset();
    issue(mk(5'b11001, 3'd4, 8'h10), 6'h0, "st_rst_handshake");
    sb.push_back(quiet(1'b0));
    step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b0), "st_rst_exec");
    sb.push_back(strb(3'd4, 3'd0, 3'd0, 1, 0, 0, 2'b00, 0, 0, 0, 1, 1));
    step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b0), "st_rst_mem0");
    sb.push_back(strb(3'd4, 3'd0, 3'd0, 1, 0, 0, 2'b00, 0, 0, 0, 1, 1));
    step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b1), "st_rst_mem1_rst");
    m_op = '0; m_lit = '0;
    sb.push_back(quiet(1'b1));
    step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b0), "st_rst_after");
  endtask

  task automatic test_back_to_back();
    logic [15:0] xor_i;
    xor_i = mk(5'b00101, 3'd6, {3'b000, 3'd7, 2'b00});
    issue(mk(5'b00010, 3'd1, {3'b000, 3'd2, 2'b00}), 6'h0, "b2b_sub_handshake");
    sb.push_back(strb(3'd1, 3'd2, 3'd1, 1, 1, 1, 2'b01, 1, 0, 0, 0, 0));
    step(inp(1'b1, xor_i, 6'h0, 1'b0, 1'b0), "b2b_sub_exec_not_ready");
    issue(xor_i, 6'h0, "b2b_xor_handshake");
    sb.push_back(strb(3'd6, 3'd7, 3'd6, 1, 1, 1, 2'b01, 1, 0, 0, 0, 0));
    step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b0), "b2b_xor_exec");
    sb.push_back(quiet(1'b1));
    step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b0), "b2b_idle");
  endtask

  task automatic test_illegal();
    issue(mk(5'b11111, 3'd3, 8'h99), 6'h0, "ill_handshake");
    sb.push_back(quiet(1'b0));
    step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b0), "ill_exec");
`ifdef DECODE_ILLEGAL_TRAP_EN
    m_ill = 1'b1;
    for (int k = 0; k < 20; k++) begin
      sb.push_back(quiet(1'b0));
      step(inp(1'b1, mk(5'b00001, 3'd1, 8'h04), 6'h0, 1'b1, 1'b0),
           $sformatf("ill_trap%0d", k));
    end
    sb.push_back(quiet(1'b0));
    step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b1), "ill_trap_rst");
    m_op = '0; m_lit = '0; m_ill = 1'b0;
    sb.push_back(quiet(1'b1));
    step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b0), "ill_cleared");
`else
    sb.push_back(quiet(1'b1));
    step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b0), "ill_nop_idle");
    issue(mk(5'b01011, 3'd2, 8'h0C), 6'h0, "rsv_handshake");
    sb.push_back(quiet(1'b0));
    step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b0), "rsv_exec");
    sb.push_back(quiet(1'b1));
    step(inp(1'b0, 16'h0, 6'h0, 1'b0, 1'b0), "rsv_idle");
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_val();
    test_ops();
    test_branch();
    test_load();
    test_store_fast();
    test_store_reset();
    test_back_to_back();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
